loa_pipe_adder: RTL and testbench

Pipelined, parametrised lower-part-OR approximate adder (LOA) with a run-time selectable approximate-region width and valid/ready flow control. It generalises the fixed-split 32-bit LOA: the OR/exact split point is chosen per transaction, and results pass through a two-stage elastic pipeline. It sits in the approximate-arithmetic datapath between operand sources and accumulators, and is a drop-in streaming replacement for combinational LOA instances.

---
 rtl/loa_pipe_if.sv | 28 ++
 rtl/loa_pipe_adder.sv | 136 +++++++++++++
 tb/tb_loa_pipe_adder.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/loa_pipe_if.sv
// Streaming operand/result bundle for loa_pipe_adder.
// slave is the adder's view of the bundle; master is the view of whatever drives it.
interface loa_pipe_if #(
  parameter int WIDTH     = 32,
  parameter int MAX_LOWER = 16,
  parameter int KW        = $clog2(MAX_LOWER + 1),
  parameter int ERR_CNT_W = 16
);
  logic                 in_valid_i;
  logic                 in_ready_o;
  logic [WIDTH-1:0]     add1_i;
  logic [WIDTH-1:0]     add2_i;
  logic [KW-1:0]        lower_i;
  logic                 out_valid_o;
  logic                 out_ready_i;
  logic [WIDTH:0]       result_o;
  logic [ERR_CNT_W-1:0] err_cnt_o;

  modport slave (
    input  in_valid_i, add1_i, add2_i, lower_i, out_ready_i,
    output in_ready_o, out_valid_o, result_o, err_cnt_o
  );

  modport master (
    output in_valid_i, add1_i, add2_i, lower_i, out_ready_i,
    input  in_ready_o, out_valid_o, result_o, err_cnt_o
  );
endinterface

// File: rtl/loa_pipe_adder.sv
// Two-stage elastic lower-part-OR approximate adder with a per-beat split point k.
// Define LOA_ERR_STAT_EN to add an exact reference adder and a saturating inexact-result counter.
module loa_pipe_adder #(
  parameter int WIDTH     = 32,
  parameter int MAX_LOWER = 16,
  parameter int KW        = $clog2(MAX_LOWER + 1),
  parameter int ERR_CNT_W = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  loa_pipe_if.slave   bus
);

  localparam logic [KW-1:0] MAX_K = KW'(MAX_LOWER);

  // S1: registered operands and clamped k
  logic             s1_valid_q, s1_valid_d;
  logic [WIDTH-1:0] s1_a_q, s1_a_d;
  logic [WIDTH-1:0] s1_b_q, s1_b_d;
  logic [KW-1:0]    s1_k_q, s1_k_d;

  // S2: registered result
  logic             out_valid_q, out_valid_d;
  logic [WIDTH:0]   result_q, result_d;

  logic             s2_load;
  logic             in_ready;
  logic [KW-1:0]    k_eff;
  logic [WIDTH-1:0] low_mask;
  logic             carry;
  logic [WIDTH:0]   approx;

  // NOTE: every variable written in always_comb gets a default first so no latch is inferred.
  always_comb begin
    k_eff = (bus.lower_i > MAX_K) ? MAX_K : bus.lower_i;

    // out_ready_i feeds in_ready_o combinationally so a release cycle can also accept.
    s2_load  = !out_valid_q || bus.out_ready_i;
    in_ready = !s1_valid_q || s2_load;

    s1_valid_d = s1_valid_q;
    s1_a_d     = s1_a_q;
    s1_b_d     = s1_b_q;
    s1_k_d     = s1_k_q;
    if (in_ready) begin
      s1_valid_d = bus.in_valid_i;
      if (bus.in_valid_i) begin
        s1_a_d = bus.add1_i;
        s1_b_d = bus.add2_i;
        s1_k_d = k_eff;
      end
    end
  end

  always_comb begin
    low_mask = '0;
    for (int i = 0; i < WIDTH; i++) begin
      low_mask[i] = (int'(s1_k_q) > i);
    end

    // Carry out of the OR region is the AND of its top bit pair.
    carry = 1'b0;
    for (int i = 0; i < MAX_LOWER; i++) begin
      if (int'(s1_k_q) == i + 1) carry = s1_a_q[i] & s1_b_q[i];
    end

    approx = ({1'b0, s1_a_q & ~low_mask} + {1'b0, s1_b_q & ~low_mask}
              + ({{WIDTH{1'b0}}, carry} << s1_k_q))
             | {1'b0, (s1_a_q | s1_b_q) & low_mask};
  end

  always_comb begin
    out_valid_d = out_valid_q;
    result_d    = result_q;
    if (s2_load) begin
      out_valid_d = s1_valid_q;
      if (s1_valid_q) result_d = approx;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s1_valid_q  <= 1'b0;
      s1_a_q      <= '0;
      s1_b_q      <= '0;
      s1_k_q      <= '0;
      out_valid_q <= 1'b0;
      result_q    <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_a_q      <= s1_a_d;
      s1_b_q      <= s1_b_d;
      s1_k_q      <= s1_k_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
    end
  end

  assign bus.in_ready_o  = in_ready;
  assign bus.out_valid_o = out_valid_q;
  assign bus.result_o    = result_q;

`ifdef LOA_ERR_STAT_EN
  logic [WIDTH:0]       exact;
  logic                 inexact_q, inexact_d;
  logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

  // The inexact flag travels with the S2 result and is counted on its output handshake.
  always_comb begin
    exact     = {1'b0, s1_a_q} + {1'b0, s1_b_q};
    inexact_d = inexact_q;
    if (s2_load && s1_valid_q) inexact_d = (approx != exact);

    err_cnt_d = err_cnt_q;
    if (out_valid_q && bus.out_ready_i && inexact_q && (err_cnt_q != '1)) begin
      err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      inexact_q <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      inexact_q <= inexact_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign bus.err_cnt_o = err_cnt_q;
`else
  assign bus.err_cnt_o = '0;
`endif

endmodule

// File: tb/tb_loa_pipe_adder.sv
// Scoreboard bench for loa_pipe_adder: driver pushes expected results, a monitor pops on output handshakes.
// Expected sums come from an arithmetic model of the LOA rules (or literal values for directed beats).
module tb_loa_pipe_adder;
  localparam int WIDTH     = 32;
  localparam int MAX_LOWER = 16;
  localparam int KW        = 5;
  localparam int ERR_CNT_W = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  loa_pipe_if #(.WIDTH(WIDTH), .MAX_LOWER(MAX_LOWER), .KW(KW), .ERR_CNT_W(ERR_CNT_W)) bus ();

  loa_pipe_adder #(.WIDTH(WIDTH), .MAX_LOWER(MAX_LOWER), .KW(KW), .ERR_CNT_W(ERR_CNT_W)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus.slave)
  );

  typedef struct {
    logic [WIDTH:0] res;
    bit             inexact;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_err    = 0;
  int   exp_err  = 0;
  bit   rand_ready = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // LOA sum from the rules: OR below k, exact add of the upper parts plus the AND carry of bit k-1.
  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input int unsigned lower);
    exp_t e;
    longint unsigned ua, ub, lo, hi, c, exact;
    int unsigned k;
    k     = (lower > MAX_LOWER) ? MAX_LOWER : lower;
    ua    = longint'(a);
    ub    = longint'(b);
    exact = ua + ub;
    if (k == 0) begin
      e.res = exact[WIDTH:0];
    end else begin
      lo = (ua | ub) % (64'd1 << k);
      c  = ((ua >> (k - 1)) & (ub >> (k - 1))) & 64'd1;
      hi = (ua >> k) + (ub >> k) + c;
      lo = (hi << k) | lo;
      e.res = lo[WIDTH:0];
    end
    e.inexact = (e.res != exact[WIDTH:0]);
    return e;
  endfunction

  // Monitor: compare on every output handshake.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && bus.out_valid_o && bus.out_ready_i) begin
        if (sb.size() == 0) begin
          check("unexpected_output", 64'(bus.out_valid_o), 64'd0);
        end else begin
          e = sb.pop_front();
          check("result", 64'(bus.result_o), 64'(e.res));
`ifdef LOA_ERR_STAT_EN
          check("err_cnt", 64'(bus.err_cnt_o), 64'(exp_err));
          if (e.inexact && exp_err < (1 << ERR_CNT_W) - 1) exp_err++;
`else
          check("err_cnt", 64'(bus.err_cnt_o), 64'd0);
`endif
        end
      end
    end
  end

  task automatic send(input logic [31:0] a, input logic [31:0] b, input int unsigned lower,
                      input exp_t e, output int waits);
    waits = 0;
    bus.add1_i     = a;
    bus.add2_i     = b;
    bus.lower_i    = KW'(lower);
    bus.in_valid_i = 1'b1;
    forever begin
      if (rand_ready) bus.out_ready_i = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      if (bus.in_ready_o) begin
        sb.push_back(e);
        @(posedge clk); #1;
        break;
      end
      @(posedge clk); #1;
      waits++;
      if (waits > 50) begin
        check("accept_timeout", 64'd0, 64'd1);
        break;
      end
    end
  endtask

  task automatic send_model(input logic [31:0] a, input logic [31:0] b, input int unsigned lower,
                            output int waits);
    send(a, b, lower, model(a, b, lower), waits);
  endtask

  task automatic idle();
    bus.in_valid_i = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic drain();
    int n;
    bus.in_valid_i  = 1'b0;
    bus.out_ready_i = 1'b1;
    n = 0;
    while ((sb.size() != 0 || bus.out_valid_o) && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    @(posedge clk); #1;
    check("drain_empty", 64'(sb.size()), 64'd0);
  endtask

  initial begin
    exp_t e;
    int w, wsum, idx;
    logic [WIDTH:0] held;
    logic [31:0] sa[5];
    logic [31:0] sbv[5];
    int unsigned sk[5];

    bus.in_valid_i  = 1'b0;
    bus.add1_i      = '0;
    bus.add2_i      = '0;
    bus.lower_i     = '0;
    bus.out_ready_i = 1'b1;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 64'(bus.out_valid_o), 64'd0);
    check("rst_result", 64'(bus.result_o), 64'd0);
    check("rst_err_cnt", 64'(bus.err_cnt_o), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    check("rst_in_ready", 64'(bus.in_ready_o), 64'd1);
    @(posedge clk); #1;

    // Directed cases with literal expectations
    e.res = 33'h0_000001FF; e.inexact = 1'b1;
    send(32'h000000FF, 32'h00000081, 8, e, w);
    e.res = 33'h1_00000000; e.inexact = 1'b0;
    send(32'hFFFFFFFF, 32'h00000001, 0, e, w);
    e.res = 33'h0_0001FFFF; e.inexact = 1'b1;
    send(32'h0000FFFF, 32'h00008000, 20, e, w);
    drain();
`ifdef LOA_ERR_STAT_EN
    check("err_directed", 64'(bus.err_cnt_o), 64'd2);
`else
    check("err_directed", 64'(bus.err_cnt_o), 64'd0);
`endif

    // Back-to-back beats with alternating k accept one per cycle
    wsum = 0;
    send_model($urandom(), $urandom(), 0, w);  wsum += w;
    send_model($urandom(), $urandom(), 8, w);  wsum += w;
    send_model($urandom(), $urandom(), 16, w); wsum += w;
    send_model($urandom(), $urandom(), 0, w);  wsum += w;
    check("b2b_accept_waits", 64'(wsum), 64'd0);
    drain();

    // Stall: two beats fill the pipe, then in_ready drops and result holds
    for (int i = 0; i < 5; i++) begin
      sa[i] = $urandom(); sbv[i] = $urandom(); sk[i] = $urandom_range(0, 31);
    end
    bus.out_ready_i = 1'b0;
    idx  = 0;
    held = '0;
    for (int cyc = 0; cyc < 5; cyc++) begin
      bus.add1_i     = sa[idx];
      bus.add2_i     = sbv[idx];
      bus.lower_i    = KW'(sk[idx]);
      bus.in_valid_i = 1'b1;
      @(negedge clk);
      if (cyc >= 3) check("stall_hold", 64'(bus.result_o), 64'(held));
      held = bus.result_o;
      if (bus.in_ready_o) begin
        sb.push_back(model(sa[idx], sbv[idx], sk[idx]));
        idx++;
      end
      if (cyc == 4) check("stall_in_ready", 64'(bus.in_ready_o), 64'd0);
      @(posedge clk); #1;
    end
    check("stall_accepts", 64'(idx), 64'd2);
    bus.out_ready_i = 1'b1;
    @(negedge clk);
    check("release_in_ready", 64'(bus.in_ready_o), 64'd1);
    if (bus.in_ready_o) begin
      sb.push_back(model(sa[idx], sbv[idx], sk[idx]));
      idx++;
    end
    @(posedge clk); #1;
    while (idx < 5) begin
      send_model(sa[idx], sbv[idx], sk[idx], w);
      idx++;
    end
    drain();

    // Random traffic with random backpressure
    rand_ready = 1'b1;
    for (int i = 0; i < 300; i++) begin
      send_model($urandom(), $urandom(), $urandom_range(0, 31), w);
      if ($urandom_range(0, 7) == 0) idle();
    end
    rand_ready = 1'b0;
    drain();
    check("err_final", 64'(bus.err_cnt_o), 64'(exp_err));

    // Reset while both stages are full
    bus.out_ready_i = 1'b0;
    send_model(32'h12345678, 32'h0F0F0F0F, 8, w);
    send_model(32'hFFFF0000, 32'h0000FFFF, 4, w);
    bus.in_valid_i = 1'b0;
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    check("midrst_out_valid", 64'(bus.out_valid_o), 64'd0);
    check("midrst_err_cnt", 64'(bus.err_cnt_o), 64'd0);
    check("midrst_result", 64'(bus.result_o), 64'd0);
    sb.delete();
    exp_err = 0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    bus.out_ready_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("no_stale_output", 64'(bus.out_valid_o), 64'd0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
